// File: rtl/reloj_time_ctrl.sv
// reloj_time_ctrl
//   Time-keeping controller for the digital clock. It generates the seconds
//   tick, sequences one-cycle increment enables into the external
//   seconds/minutes/hours counter chain (including the 23:59:59 carry), runs
//   the RUN / SET_HR / SET_MIN set-time machine from two debounced buttons, and
//   drives the display blink enable. It holds no time registers of its own.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active-high
//   btn_mode  in   debounced mode button level
//   btn_inc   in   debounced increment button level
//   sec_tc    in   seconds counter at 59
//   min_tc    in   minutes counter at 59
//   sec_inc   out  one-cycle seconds increment enable
//   min_inc   out  one-cycle minutes increment enable
//   hr_inc    out  one-cycle hours increment enable
//   sec_clr   out  one-cycle seconds clear (on SET_MIN -> RUN)
//   mode      out  00 RUN, 01 SET_HR, 10 SET_MIN
//   blink     out  display blink enable
module reloj_time_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       sec_tc,
  input  logic       min_tc,
  output logic       sec_inc,
  output logic       min_inc,
  output logic       hr_inc,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10,
    ILLEGAL = 2'b11
  } mode_e;

  mode_e          mode_q, mode_d;
  logic           btn_mode_q, btn_inc_q;
  logic [TW-1:0]  pres_q, pres_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;
  logic           blink_q, blink_d;
  logic           sec_inc_q, sec_inc_d;
  logic           min_inc_q, min_inc_d;
  logic           hr_inc_q, hr_inc_d;
  logic           sec_clr_q, sec_clr_d;

  logic mode_ev, inc_ev, tick, in_set;

  // History regs reset to 1 so a button held through reset produces no edge.
  assign mode_ev = btn_mode & ~btn_mode_q;
  assign inc_ev  = btn_inc  & ~btn_inc_q;
  assign tick    = (pres_q == TICK_MAX);
  assign in_set  = (mode_q == SET_HR) || (mode_q == SET_MIN);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= RUN;
      btn_mode_q <= 1'b1;
      btn_inc_q  <= 1'b1;
      pres_q     <= '0;
      bcnt_q     <= '0;
      blink_q    <= 1'b0;
      sec_inc_q  <= 1'b0;
      min_inc_q  <= 1'b0;
      hr_inc_q   <= 1'b0;
      sec_clr_q  <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      btn_mode_q <= btn_mode;
      btn_inc_q  <= btn_inc;
      pres_q     <= pres_d;
      bcnt_q     <= bcnt_d;
      blink_q    <= blink_d;
      sec_inc_q  <= sec_inc_d;
      min_inc_q  <= min_inc_d;
      hr_inc_q   <= hr_inc_d;
      sec_clr_q  <= sec_clr_d;
    end
  end

  // Mode sequencing: RUN -> SET_HR -> SET_MIN -> RUN on each mode press
  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      RUN:     if (mode_ev) mode_d = SET_HR;
      SET_HR:  if (mode_ev) mode_d = SET_MIN;
      SET_MIN: if (mode_ev) mode_d = RUN;
      default: mode_d = RUN;
    endcase
  end

  // Next values of the registered outputs, prescaler and blink counter
  always_comb begin
    pres_d    = '0;
    bcnt_d    = '0;
    blink_d   = 1'b0;
    sec_inc_d = 1'b0;
    min_inc_d = 1'b0;
    hr_inc_d  = 1'b0;
    sec_clr_d = 1'b0;

    unique case (mode_q)
      RUN: begin
        pres_d    = tick ? '0 : pres_q + TW'(1);
        sec_inc_d = tick;
        min_inc_d = tick & sec_tc;
        hr_inc_d  = tick & sec_tc & min_tc;
      end
      // A mode press in the same cycle as an increment press swallows it.
      SET_HR:  hr_inc_d = inc_ev & ~mode_ev;
      SET_MIN: begin
        min_inc_d = inc_ev & ~mode_ev;
        sec_clr_d = mode_ev;
      end
      default: ;
    endcase

    // Blink restarts from 0 on every mode change and is idle outside set modes.
    if (in_set && (mode_d == mode_q)) begin
      if (bcnt_q == BLINK_MAX) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d  = bcnt_q + BW'(1);
        blink_d = blink_q;
      end
    end
  end

  assign sec_inc = sec_inc_q;
  assign min_inc = min_inc_q;
  assign hr_inc  = hr_inc_q;
  assign sec_clr = sec_clr_q;
  assign mode    = mode_q;
  assign blink   = blink_q;

endmodule

// File: tb/tb_reloj_time_ctrl.sv
module tb_reloj_time_ctrl;

  logic       clk = 1'b0;
  logic       rst, btn_mode, btn_inc, sec_tc, min_tc;
  logic       sec_inc, min_inc, hr_inc, sec_clr, blink;
  logic [1:0] mode;

  int total  = 0;
  int passed = 0;
  int npulse;

  reloj_time_ctrl #(.TICK_DIV(4), .BLINK_DIV(3)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_tc(sec_tc), .min_tc(min_tc), .sec_inc(sec_inc), .min_inc(min_inc),
    .hr_inc(hr_inc), .sec_clr(sec_clr), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input int e_mode, input int e_s,
                         input int e_m, input int e_h, input int e_c, input int e_b);
    chk({tag, ".mode"},    int'(mode),    e_mode);
    chk({tag, ".sec_inc"}, int'(sec_inc), e_s);
    chk({tag, ".min_inc"}, int'(min_inc), e_m);
    chk({tag, ".hr_inc"},  int'(hr_inc),  e_h);
    chk({tag, ".sec_clr"}, int'(sec_clr), e_c);
    chk({tag, ".blink"},   int'(blink),   e_b);
  endtask

  initial begin
    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; sec_tc = 1'b0; min_tc = 1'b0;
    step();
    step();
    chk_all("reset", 0, 0, 0, 0, 0, 0);

    // 1: plain seconds ticks every 4 cycles after reset release
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk_all($sformatf("run_tick%0d", i), 0, (i % 4 == 0) ? 1 : 0, 0, 0, 0, 0);
    end

    // 2: minute carry, then full 23:59:59 rollover carry
    sec_tc = 1'b1; min_tc = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 4) chk_all("min_carry", 0, 1, 1, 0, 0, 0);
      else        chk_all($sformatf("min_carry_wait%0d", i), 0, 0, 0, 0, 0, 0);
    end
    sec_tc = 1'b1; min_tc = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 4) chk_all("hr_carry", 0, 1, 1, 1, 0, 0);
      else        chk_all($sformatf("hr_carry_wait%0d", i), 0, 0, 0, 0, 0, 0);
    end
    sec_tc = 1'b0; min_tc = 1'b0;

    // 3: enter SET_HR, blink period 3, no seconds ticks
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    chk_all("set_hr_enter", 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk_all($sformatf("set_hr_blink%0d", k), 1, 0, 0, 0, 0, (k / 3) % 2);
    end
    btn_inc = 1'b1;
    npulse = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (hr_inc) npulse++;
      if (k == 1) chk("set_hr_first_inc", int'(hr_inc), 1);
    end
    chk("set_hr_held_pulses", npulse, 1);
    btn_inc = 1'b0;
    step();

    // 4: SET_MIN, blink restart, no hour carry, exit with sec_clr
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    chk_all("set_min_enter", 2, 0, 0, 0, 0, 0);
    step();
    step();
    chk("set_min_blink_k2", int'(blink), 0);
    step();
    chk("set_min_blink_k3", int'(blink), 1);
    sec_tc = 1'b1; min_tc = 1'b1; btn_inc = 1'b1;
    step();
    btn_inc = 1'b0;
    chk("set_min_inc.min_inc", int'(min_inc), 1);
    chk("set_min_inc.hr_inc",  int'(hr_inc),  0);
    chk("set_min_inc.sec_inc", int'(sec_inc), 0);
    step();
    chk("set_min_inc_done", int'(min_inc), 0);
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0; sec_tc = 1'b0; min_tc = 1'b0;
    chk_all("exit_run", 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_all($sformatf("exit_tick%0d", i), 0, (i == 4) ? 1 : 0, 0, 0, 0, 0);
    end

    // 5: simultaneous mode and inc presses in SET_HR
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    step();
    chk("to_set_hr", int'(mode), 1);
    btn_mode = 1'b1; btn_inc = 1'b1;
    step();
    btn_mode = 1'b0; btn_inc = 1'b0;
    chk_all("mode_wins", 2, 0, 0, 0, 0, 0);
    step();

    // 6: reset in SET_MIN while blinking, button held through reset
    step();
    step();
    chk("pre_rst_blink", int'(blink), 1);
    rst = 1'b1; btn_mode = 1'b1;
    step();
    rst = 1'b0;
    chk_all("mid_reset", 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("held_through_reset%0d", i), int'(mode), 0);
    end
    btn_mode = 1'b0;
    step();
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    chk("post_reset_press", int'(mode), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
